// File: rtl/mem_pkg.sv
// Shared types and constants for the memory execution unit and its interfaces.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef AL_SIZE
`define AL_SIZE 64
`endif

package mem_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} mem_state_t;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;
endpackage

// File: rtl/mem_ifc.sv
// Issue-queue (miq_ifc) and writeback (wb_ifc) bundles used by mem_exec_unit.
interface miq_ifc #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int AL_W       = $clog2(`AL_SIZE)
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] pc;
  logic [4:0]            rd;
  logic                  uses_rd;
  logic [DATA_WIDTH-1:0] imm;
  logic                  uses_imm;
  logic                  is_mem_access;
  logic                  mem_access_type;
  logic [2:0]            width;
  logic [AL_W-1:0]       al_addr;

  modport in  (input  valid, pc, rd, uses_rd, imm, uses_imm, is_mem_access, mem_access_type, width, al_addr);
  modport out (output valid, pc, rd, uses_rd, imm, uses_imm, is_mem_access, mem_access_type, width, al_addr);
endinterface

interface wb_ifc #(
  parameter int DATA_WIDTH = 32,
  parameter int AL_W       = $clog2(`AL_SIZE)
);
  logic                  valid;
  logic [4:0]            rd;
  logic                  uses_rd;
  logic [DATA_WIDTH-1:0] data;
  logic [AL_W-1:0]       al_addr;

  modport out (output valid, rd, uses_rd, data, al_addr);
  modport in  (input  valid, rd, uses_rd, data, al_addr);
endinterface

// File: rtl/mem_load_formatter.sv
// Combinational load-data aligner: picks the byte/half/word at the address and extends it.
module mem_load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_width,
  output logic [31:0] o_result
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_addr_lo +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_width)
      W_B:     o_result = {{24{w_byte[7]}}, w_byte};
      W_BU:    o_result = {24'h0, w_byte};
      W_H:     o_result = {{16{w_half[15]}}, w_half};
      W_HU:    o_result = {16'h0, w_half};
      default: o_result = i_rdata;
    endcase
  end
endmodule

// File: rtl/mem_exec_unit.sv
// Memory execution unit: address generation, one-outstanding dmem handshake,
// load formatting, checkpoint-recall kill and single-cycle writeback.
module mem_exec_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int AL_W       = $clog2(`AL_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  miq_ifc.in                    i_miq,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic                  if_recall,
  input  logic [AL_W-1:0]       new_front,
  input  logic [AL_W-1:0]       old_front,
  output logic                  busy,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [3:0]            dmem_req_be,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
  wb_ifc.out                    o_wb,
  output logic                  misalign
);
  mem_state_t            r_state;
  logic [4:0]            r_rd;
  logic                  r_uses_rd;
  logic [AL_W-1:0]       r_al;
  logic                  r_is_mem;
  logic                  r_we;
  logic                  r_misal;
  logic [2:0]            r_width;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_rs2;
  logic [DATA_WIDTH-1:0] r_data;

  logic [DATA_WIDTH-1:0] w_addr;
  logic                  w_misal;
  logic                  w_kill;
  logic                  w_req;
  logic                  w_wb;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_fmt;
  logic                  w_unused_pc;

  // Circular active-list range [nf, of); handles wrap past the top of the list.
  function automatic logic in_range(input logic [AL_W-1:0] a, input logic [AL_W-1:0] nf,
                                    input logic [AL_W-1:0] of);
    return (nf <= of) ? (a >= nf && a < of) : (a >= nf || a < of);
  endfunction

  assign w_unused_pc = ^i_miq.pc;

  always_comb begin
    w_addr  = rs1_val + (i_miq.uses_imm ? i_miq.imm : '0);
    w_misal = (i_miq.width[1:0] == 2'b01 && w_addr[0]) ||
              (i_miq.width[1:0] == 2'b10 && w_addr[1:0] != 2'b00);
    w_kill  = if_recall && in_range(r_al, new_front, old_front);
    case (r_width[1:0])
      2'b00:   begin w_be = 4'b0001 << r_addr[1:0]; w_wdata = {4{r_rs2[7:0]}};  end
      2'b01:   begin w_be = 4'b0011 << r_addr[1:0]; w_wdata = {2{r_rs2[15:0]}}; end
      default: begin w_be = 4'b1111;                w_wdata = r_rs2;            end
    endcase
  end

  mem_load_formatter u_fmt (
    .i_rdata   (dmem_resp_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_width   (r_width),
    .o_result  (w_fmt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:  if (i_miq.valid) r_state <= (!i_miq.is_mem_access || w_misal) ? WB : REQ;
        // A handshake in the same cycle as a kill still commits the access.
        REQ:   if (dmem_req_ready) r_state <= r_we ? WB : (w_kill ? DRAIN : WAIT);
               else if (w_kill)    r_state <= IDLE;
        WAIT:  if (w_kill)               r_state <= dmem_resp_valid ? IDLE : DRAIN;
               else if (dmem_resp_valid) r_state <= WB;
        WB:    r_state <= IDLE;
        DRAIN: if (dmem_resp_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && i_miq.valid) begin
      r_rd      <= i_miq.rd;
      r_uses_rd <= i_miq.uses_rd;
      r_al      <= i_miq.al_addr;
      r_is_mem  <= i_miq.is_mem_access;
      r_we      <= i_miq.mem_access_type;
      r_misal   <= i_miq.is_mem_access && w_misal;
      r_width   <= i_miq.width;
      r_addr    <= w_addr;
      r_rs2     <= rs2_val;
      r_data    <= '0;
    end else if (r_state == WAIT && dmem_resp_valid) begin
      r_data <= w_fmt;
    end
  end

  // Outputs are gated by state so nothing leaks from uninitialised data registers.
  always_comb begin
    busy            = (r_state != IDLE);
    w_req           = (r_state == REQ);
    w_wb            = (r_state == WB) && !w_kill;
    dmem_req_valid  = w_req;
    dmem_req_we     = w_req && r_we;
    dmem_req_addr   = w_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    dmem_req_be     = w_req ? w_be : 4'b0000;
    dmem_req_wdata  = w_req ? w_wdata : '0;
    o_wb.valid      = w_wb;
    o_wb.rd         = w_wb ? r_rd : 5'd0;
    o_wb.uses_rd    = w_wb && r_uses_rd && !(r_is_mem && r_we == MEM_STORE) && !r_misal;
    o_wb.data       = w_wb ? r_data : '0;
    o_wb.al_addr    = w_wb ? r_al : '0;
    misalign        = w_wb && r_misal;
  end

  a_no_issue_while_busy: assert property (@(posedge clk) disable iff (!reset)
    !(busy && i_miq.valid));
endmodule

// File: tb/tb_mem_exec_unit.sv
// Directed bench for mem_exec_unit: stores, load formatting, misalignment, backpressure, recall, reset.
module tb_mem_exec_unit;
  import mem_pkg::*;
  localparam int AL_W = $clog2(`AL_SIZE);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rs1_val = '0, rs2_val = '0;
  logic        if_recall = 1'b0;
  logic [AL_W-1:0] new_front = '0, old_front = '0;
  logic        busy, dmem_req_valid, dmem_req_we, misalign;
  logic        dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [31:0] dmem_resp_rdata = '0;
  logic [3:0]  dmem_req_be;
  int total = 0;
  int bad = 0;

  miq_ifc #(.DATA_WIDTH(32), .ADDR_WIDTH(`ADDR_WIDTH), .AL_W(AL_W)) miq ();
  wb_ifc  #(.DATA_WIDTH(32), .AL_W(AL_W)) wbi ();

  mem_exec_unit dut (
    .clk(clk), .reset(reset), .i_miq(miq), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .if_recall(if_recall), .new_front(new_front), .old_front(old_front), .busy(busy),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
    .dmem_req_addr(dmem_req_addr), .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata), .o_wb(wbi),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] w, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] data,
                       input logic [AL_W-1:0] al, input logic mem);
    miq.pc = 32'h100; miq.rd = 5'd9; miq.uses_rd = 1'b1;
    miq.imm = imm; miq.uses_imm = (imm != 0);
    miq.is_mem_access = mem; miq.mem_access_type = st; miq.width = w; miq.al_addr = al;
    rs1_val = base; rs2_val = data;
    miq.valid = 1'b1;
    step();
    miq.valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", dmem_req_valid); end
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL rst_wb got=%0h exp=0", wbi.valid); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_mis got=%0h exp=0", misalign); end
    total++; if (dmem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", dmem_req_addr); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    dmem_req_ready = 1'b1;
    issue(MEM_STORE, W_W, 32'h1000, 32'd4, 32'hDEADBEEF, 6'd7, 1'b1);
    total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL sw_req got=%0h exp=1", dmem_req_valid); end
    total++; if (dmem_req_addr !== 32'h1004) begin bad++; $display("FAIL sw_addr got=%0h exp=1004", dmem_req_addr); end
    total++; if (dmem_req_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%0h exp=f", dmem_req_be); end
    total++; if (dmem_req_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%0h exp=deadbeef", dmem_req_wdata); end
    total++; if (dmem_req_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%0h exp=1", dmem_req_we); end
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL sw_wb_early got=%0h exp=0", wbi.valid); end
    step();
    total++; if (wbi.valid !== 1'b1) begin bad++; $display("FAIL sw_wb got=%0h exp=1", wbi.valid); end
    total++; if (wbi.uses_rd !== 1'b0) begin bad++; $display("FAIL sw_uses_rd got=%0h exp=0", wbi.uses_rd); end
    total++; if (wbi.al_addr !== 6'd7) begin bad++; $display("FAIL sw_al got=%0d exp=7", wbi.al_addr); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sw_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_store_byte_half();
    dmem_req_ready = 1'b1;
    issue(MEM_STORE, W_B, 32'h5002, 32'd0, 32'h000000A5, 6'd1, 1'b1);
    total++; if (dmem_req_be !== 4'b0100) begin bad++; $display("FAIL sb_be got=%0h exp=4", dmem_req_be); end
    total++; if (dmem_req_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%0h exp=a5a5a5a5", dmem_req_wdata); end
    step(); step();
    issue(MEM_STORE, W_H, 32'h5002, 32'd0, 32'h00001234, 6'd1, 1'b1);
    total++; if (dmem_req_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%0h exp=c", dmem_req_be); end
    total++; if (dmem_req_wdata !== 32'h12341234) begin bad++; $display("FAIL sh_wdata got=%0h exp=12341234", dmem_req_wdata); end
    step(); step();
  endtask

  task automatic test_load_fmt(input logic [2:0] w, input logic [31:0] addr,
                               input logic [31:0] rdata, input logic [31:0] exp, input string nm);
    dmem_req_ready = 1'b1;
    issue(MEM_LOAD, w, addr, 32'd0, 32'd0, 6'd2, 1'b1);
    total++; if (dmem_req_we !== 1'b0) begin bad++; $display("FAIL %s_we got=%0h exp=0", nm, dmem_req_we); end
    step();
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL %s_wait got=%0h exp=0", nm, wbi.valid); end
    dmem_resp_valid = 1'b1; dmem_resp_rdata = rdata;
    step();
    dmem_resp_valid = 1'b0;
    total++; if (wbi.valid !== 1'b1) begin bad++; $display("FAIL %s_wb got=%0h exp=1", nm, wbi.valid); end
    total++; if (wbi.data !== exp) begin bad++; $display("FAIL %s_data got=%0h exp=%0h", nm, wbi.data, exp); end
    total++; if (wbi.uses_rd !== 1'b1) begin bad++; $display("FAIL %s_uses_rd got=%0h exp=1", nm, wbi.uses_rd); end
    step();
  endtask

  task automatic test_misaligned();
    dmem_req_ready = 1'b1;
    issue(MEM_STORE, W_H, 32'h3001, 32'd0, 32'h1234, 6'd4, 1'b1);
    total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL mis_req got=%0h exp=0", dmem_req_valid); end
    total++; if (wbi.valid !== 1'b1) begin bad++; $display("FAIL mis_wb got=%0h exp=1", wbi.valid); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_flag got=%0h exp=1", misalign); end
    total++; if (wbi.uses_rd !== 1'b0) begin bad++; $display("FAIL mis_uses_rd got=%0h exp=0", wbi.uses_rd); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_backpressure();
    int pulses;
    dmem_req_ready = 1'b0;
    issue(MEM_LOAD, W_W, 32'h4008, 32'd0, 32'd0, 6'd10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_req_ready = 1'b1;
      total++; if (dmem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_req%0d got=%0h exp=1", i, dmem_req_valid); end
      total++; if (dmem_req_addr !== 32'h4008) begin bad++; $display("FAIL bp_addr%0d got=%0h exp=4008", i, dmem_req_addr); end
      total++; if (dmem_req_be !== 4'hF) begin bad++; $display("FAIL bp_be%0d got=%0h exp=f", i, dmem_req_be); end
      step();
    end
    dmem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy%0d got=%0h exp=1", i, busy); end
      total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL bp_nowb%0d got=%0h exp=0", i, wbi.valid); end
      step();
    end
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h12345678;
    step();
    dmem_resp_valid = 1'b0;
    total++; if (wbi.data !== 32'h12345678) begin bad++; $display("FAIL bp_data got=%0h exp=12345678", wbi.data); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (wbi.valid === 1'b1) pulses++;
      step();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL bp_pulses got=%0d exp=1", pulses); end
    dmem_req_ready = 1'b1;
  endtask

  task automatic test_recall_kill(input logic [AL_W-1:0] al, input logic [AL_W-1:0] nf,
                                  input logic [AL_W-1:0] of, input string nm);
    dmem_req_ready = 1'b1;
    issue(MEM_LOAD, W_W, 32'h6000, 32'd0, 32'd0, al, 1'b1);
    step();
    if_recall = 1'b1; new_front = nf; old_front = of;
    step();
    if_recall = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_drain got=%0h exp=1", nm, busy); end
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL %s_nowb got=%0h exp=0", nm, wbi.valid); end
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hCAFE0000;
    step();
    dmem_resp_valid = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle got=%0h exp=0", nm, busy); end
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL %s_nowb2 got=%0h exp=0", nm, wbi.valid); end
  endtask

  task automatic test_recall_misc();
    // al_addr=3 outside [4,9): load completes normally
    dmem_req_ready = 1'b1;
    issue(MEM_LOAD, W_W, 32'h6000, 32'd0, 32'd0, 6'd3, 1'b1);
    step();
    if_recall = 1'b1; new_front = 6'd4; old_front = 6'd9;
    step();
    if_recall = 1'b0;
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL rc_live_wait got=%0h exp=0", wbi.valid); end
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'h0BADF00D;
    step();
    dmem_resp_valid = 1'b0;
    total++; if (wbi.valid !== 1'b1) begin bad++; $display("FAIL rc_live_wb got=%0h exp=1", wbi.valid); end
    total++; if (wbi.data !== 32'h0BADF00D) begin bad++; $display("FAIL rc_live_data got=%0h exp=badf00d", wbi.data); end
    step();
    // non-memory op goes straight to WB; recall during WB suppresses it
    issue(MEM_LOAD, W_W, 32'h7777, 32'd0, 32'd0, 6'd6, 1'b0);
    total++; if (wbi.valid !== 1'b1) begin bad++; $display("FAIL rc_nm_wb got=%0h exp=1", wbi.valid); end
    total++; if (wbi.data !== 32'h0) begin bad++; $display("FAIL rc_nm_data got=%0h exp=0", wbi.data); end
    if_recall = 1'b1;
    #1;
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL rc_wb_kill got=%0h exp=0", wbi.valid); end
    step();
    if_recall = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rc_wb_idle got=%0h exp=0", busy); end
    // kill in REQ with no handshake drops the request
    dmem_req_ready = 1'b0;
    issue(MEM_LOAD, W_W, 32'h6000, 32'd0, 32'd0, 6'd5, 1'b1);
    if_recall = 1'b1;
    step();
    if_recall = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rc_req_idle got=%0h exp=0", busy); end
    total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rc_req_drop got=%0h exp=0", dmem_req_valid); end
    dmem_req_ready = 1'b1;
  endtask

  task automatic test_reset_in_wait();
    dmem_req_ready = 1'b1;
    issue(MEM_LOAD, W_W, 32'h8000, 32'd0, 32'd0, 6'd12, 1'b1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rw_busy got=%0h exp=0", busy); end
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL rw_wb got=%0h exp=0", wbi.valid); end
    total++; if (dmem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_req got=%0h exp=0", dmem_req_valid); end
    dmem_resp_valid = 1'b1;
    step();
    dmem_resp_valid = 1'b0;
    total++; if (wbi.valid !== 1'b0) begin bad++; $display("FAIL rw_late_wb got=%0h exp=0", wbi.valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rw_late_busy got=%0h exp=0", busy); end
  endtask

  initial begin
    miq.valid = 1'b0; miq.pc = '0; miq.rd = '0; miq.uses_rd = 1'b0; miq.imm = '0;
    miq.uses_imm = 1'b0; miq.is_mem_access = 1'b0; miq.mem_access_type = 1'b0;
    miq.width = '0; miq.al_addr = '0;
    #1;
    test_reset();
    test_store_word();
    test_store_byte_half();
    test_load_fmt(W_B,  32'h2003, 32'h80FF0000, 32'hFFFFFF80, "lb");
    test_load_fmt(W_BU, 32'h2003, 32'h80FF0000, 32'h00000080, "lbu");
    test_load_fmt(W_HU, 32'h2002, 32'h80FF0000, 32'h000080FF, "lhu");
    test_load_fmt(W_H,  32'h2002, 32'h80FF0000, 32'hFFFF80FF, "lh");
    test_misaligned();
    test_backpressure();
    test_recall_kill(6'd5, 6'd4, 6'd9, "rc_in");
    test_recall_kill(6'd1, 6'd60, 6'd2, "rc_wrap");
    test_recall_misc();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_exec_unit.md
Name: mem_exec_unit

Overview:
- Consumer end of the memory issue queue interface (miq_ifc). It takes one issued load or store per operation and computes the effective address.
- It runs a valid/ready request plus a response handshake with the data memory, formats load data and returns completion on a wb_ifc port.
- Its busy output drives the queue's ext_stall. It sits between the in-order memory IQ / register read and the writeback network.

Parameters:
- DATA_WIDTH, 32, data bus and register width; only 32 is supported.
- ADDR_WIDTH, `ADDR_WIDTH, memory address width.
- AL_W, $clog2(`AL_SIZE), active-list tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- i_miq  in  miq_ifc.in  issued op: valid, pc, rd, uses_rd, imm, uses_imm, is_mem_access, mem_access_type (0=load, 1=store), width[2:0], al_addr.
- rs1_val  in  32  base operand; valid in the same cycle as i_miq.valid.
- rs2_val  in  32  store data; valid in the same cycle as i_miq.valid.
- if_recall  in  1  checkpoint recall.
- new_front  in  AL_W  start of the killed active-list range.
- old_front  in  AL_W  end of the killed range (exclusive).
- busy  out  1  unit cannot accept an op; drives IQ ext_stall.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = store.
- dmem_req_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
- dmem_req_be  out  4  byte enables.
- dmem_req_wdata  out  32  lane-replicated store data.
- dmem_resp_valid  in  1  read data returned; only for loads.
- dmem_resp_rdata  in  32  read word.
- o_wb  out  wb_ifc.out  completion: valid, rd, uses_rd, data, al_addr.
- misalign  out  1  qualifies o_wb.valid; the op faulted and no memory access was made.

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, busy=0, dmem_req_valid=0, o_wb.valid=0, misalign=0. All other outputs are 0. Reset overrides everything, including a pending handshake.
- busy = (state != IDLE). i_miq.valid is sampled only in IDLE. i_miq.valid while busy is a protocol violation; assert on it in simulation.
- Capture (IDLE, i_miq.valid):
  - Register all i_miq fields and rs2_val.
  - addr = rs1_val + (uses_imm ? imm : 0), mod 2^32.
  - Next state: if is_mem_access=0 go to WB with data=0. If misaligned, go to WB with misalign=1. Otherwise go to REQ.
- Misalignment: width[1:0]=01 with addr[0]!=0, or width[1:0]=10 with addr[1:0]!=0.
- Width codes: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
- Store write data: SB {4{b}}, SH {2{h}}, SW word.
- REQ:
  - dmem_req_valid=1. Address, be, we and wdata are held stable until dmem_req_ready.
  - On handshake, a store goes to WB and a load goes to WAIT.
- WAIT: on dmem_resp_valid, latch the formatted data (see the load rule below) and go to WB.
- Load formatting: select the byte/half at addr[1:0] (half at addr[1]). Sign-extend for LB/LH; zero-extend for LBU/LHU.
- WB:
  - One-cycle o_wb.valid=1 with the captured rd, al_addr and data.
  - uses_rd = captured uses_rd, forced to 0 for stores and misaligned ops.
  - Then return to IDLE; the next op may be accepted the same cycle busy falls.
- Latency, no backpressure:
  - Accept at edge N. dmem_req_valid is high in cycle N+1.
  - Store: o_wb.valid in cycle N+2.
  - Load: o_wb.valid one cycle after dmem_resp_valid.
  - Misaligned/non-mem op: o_wb.valid in cycle N+1.
- Recall:
  - kill = if_recall && captured al_addr lies in the circular range [new_front, old_front).
  - Circular range: (new_front<=old_front) ? (a>=new_front && a<old_front) : (a>=new_front || a<old_front).
  - REQ with no handshake in the same cycle: drop to IDLE with no request.
  - REQ with a handshake in the same cycle: the handshake wins. A store proceeds and completes; a load goes to DRAIN.
  - WAIT: go to DRAIN; if resp arrives the same cycle, go to IDLE.
  - WB: suppress o_wb.valid and go to IDLE.
  - A capture in the same cycle as a recall: capture proceeds; IQ gating prevents killed ops from issuing.
- DRAIN: busy=1. Discard the next dmem_resp_valid, then go to IDLE. No writeback.
- Only one outstanding memory request at any time.

Decomposition:
- Shared package mem_pkg:
  - mem_state_t enum: IDLE, REQ, WAIT, WB, DRAIN.
  - Width localparams: W_B, W_H, W_W, W_BU, W_HU.
  - MEM_LOAD/MEM_STORE constants.
- Sub-module mem_load_formatter (combinational): inputs rdata, addr[1:0], width; output 32-bit result. It is reusable by a future store-to-load forwarding path.
- FSM, capture registers and the recall range check live in mem_exec_unit.

Test Plan:
- SW: rs1_val=0x1000, imm=4, rs2_val=0xDEADBEEF, ready=1.
  - Expect addr=0x1004, be=1111, wdata=0xDEADBEEF, we=1.
  - o_wb.valid 2 cycles after accept, uses_rd=0.
- LB addr=0x2003, rdata=0x80FF0000.
  - Expect data=0xFFFFFF80.
  - LBU at the same address gives 0x00000080; LHU at 0x2002 gives 0x000080FF.
- SH addr=0x3001: expect no dmem_req_valid, o_wb.valid next cycle with misalign=1, uses_rd=0.
- Load with ready held low 3 cycles, then resp 2 cycles later.
  - Expect addr/be stable throughout and busy=1 until WB.
  - Expect exactly one o_wb pulse.
- Load al_addr=5 in WAIT, recall new_front=4, old_front=9.
  - Expect DRAIN, the resp discarded, no o_wb.
  - A wrap case (new_front=60, old_front=2, al_addr=1) also kills.
  - al_addr=3 is not killed.
- Reset asserted in WAIT: next cycle state IDLE, busy=0, no o_wb.
